axi2ahb_wr_fifo: RTL and testbench

Write-data and write-response stage of the AXI-to-AHB bridge. It buffers AXI W-channel beats and presents them on HWDATA during AHB write data phases. It tells the AHB control stage when a complete burst is buffered. It collects per-burst AHB error status and returns it on the AXI B channel. It is the write-direction counterpart of the read-data FIFO and sits between the AXI slave ports and the AHB master control.

---
 rtl/axi2ahb_wr_fifo_pkg.sv | 40 ++++
 rtl/axi2ahb_wr_fifo_prgen_fifo.sv | 59 +++++
 rtl/axi2ahb_wr_fifo.sv | 115 +++++++++++
 tb/tb_axi2ahb_wr_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2ahb_wr_fifo_pkg.sv
// Shared constants, types and helpers for the AXI-to-AHB write-data/response stage.
// The optional AXI2AHB_WID_CHECK_EN macro widens the data FIFO to carry WID per beat.
package axi2ahb_wr_fifo_pkg;

  localparam int DATA_BITS  = 32;
  localparam int ID_BITS    = 4;
  localparam int FIFO_LINES = 32;
  localparam int CMD_DEPTH  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Ceiling log2, with log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  localparam int CNT_BITS = log2(CMD_DEPTH) + 1;

`ifdef AXI2AHB_WID_CHECK_EN
  localparam int DFIFO_BITS = DATA_BITS + ID_BITS + 1;
`else
  localparam int DFIFO_BITS = DATA_BITS + 1;
`endif

  localparam int RFIFO_BITS = ID_BITS + 2;

endpackage

// File: rtl/axi2ahb_wr_fifo_prgen_fifo.sv
// Generic synchronous FIFO (prgen_fifo): pushes into a full FIFO and pops from an
// empty one are ignored; the head is presented combinationally and reads as zero when empty.
module prgen_fifo
  import axi2ahb_wr_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_BITS = (DEPTH > 1) ? log2(DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(DEPTH - 1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                push_ok;
  logic                pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array is deliberately left unreset; only pointers and
  // count define validity, and a resettable RAM would block memory inference.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi2ahb_wr_fifo.sv
// AXI-to-AHB write-data and write-response stage: buffers W beats for HWDATA, counts
// complete bursts, accumulates AHB errors and returns B responses. Option: AXI2AHB_WID_CHECK_EN.
module axi2ahb_wr_fifo
  import axi2ahb_wr_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BITS-1:0]   WID,
  input  logic [DATA_BITS-1:0] WDATA,
  input  logic                 WLAST,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [ID_BITS-1:0]   BID,
  output logic [1:0]           BRESP,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [DATA_BITS-1:0] HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic                 cmd_err,
  input  logic                 wdata_phase,
  input  logic                 data_last,
  output logic                 wdata_ready
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(CMD_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [DFIFO_BITS-1:0] d_din;
  logic [DFIFO_BITS-1:0] d_dout;
  logic                  data_empty;
  logic                  data_full;
  logic [RFIFO_BITS-1:0] r_din;
  logic [RFIFO_BITS-1:0] r_dout;
  logic                  resp_empty;
  logic                  resp_full;
  logic [CNT_BITS-1:0]   burst_cnt;
  logic                  err_acc;
  logic                  burst_err;
  logic                  wid_err;
  logic                  w_push;
  logic                  d_pop;
  logic                  axi_last;
  logic                  ahb_last;
  logic                  unused_ok;

  assign WREADY   = reset & ~data_full & (burst_cnt < CNT_MAX);
  assign w_push   = WVALID & WREADY;
  assign d_pop    = wdata_phase & HREADY;
  assign axi_last = w_push & WLAST;
  assign ahb_last = wdata_phase & HREADY & data_last;
  assign HWDATA   = d_dout[DATA_BITS:1];

`ifdef AXI2AHB_WID_CHECK_EN
  assign d_din     = {WID, WDATA, WLAST};
  assign wid_err   = d_pop & ~data_empty & (d_dout[DFIFO_BITS-1 -: ID_BITS] != cmd_id);
  assign unused_ok = &{1'b0, d_dout[0]};
`else
  assign d_din     = {WDATA, WLAST};
  assign wid_err   = 1'b0;
  assign unused_ok = &{1'b0, d_dout[0], WID};
`endif

  prgen_fifo #(
    .WIDTH (DFIFO_BITS),
    .DEPTH (FIFO_LINES)
  ) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (d_pop),
    .din   (d_din),
    .dout  (d_dout),
    .empty (data_empty),
    .full  (data_full)
  );

  // Error status of the burst in progress, including whatever this cycle reports.
  assign burst_err = err_acc | cmd_err | (wdata_phase & HRESP) | wid_err;
  assign r_din     = {cmd_id, burst_err ? RESP_SLVERR : RESP_OKAY};

  prgen_fifo #(
    .WIDTH (RFIFO_BITS),
    .DEPTH (CMD_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ahb_last),
    .pop   (BVALID & BREADY),
    .din   (r_din),
    .dout  (r_dout),
    .empty (resp_empty),
    .full  (resp_full)
  );

  assign BVALID       = ~resp_empty;
  assign {BID, BRESP} = r_dout;
  assign wdata_ready  = (burst_cnt != '0) & ~resp_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
      err_acc   <= 1'b0;
    end else begin
      case ({axi_last, ahb_last})
        2'b10:   burst_cnt <= burst_cnt + CNT_ONE;
        2'b01:   burst_cnt <= burst_cnt - CNT_ONE;
        default: burst_cnt <= burst_cnt;
      endcase
      err_acc <= ahb_last ? 1'b0 : burst_err;
    end
  end

endmodule

// File: tb/tb_axi2ahb_wr_fifo.sv
// Scoreboard bench for axi2ahb_wr_fifo: AXI beats and B responses are predicted into
// queues and compared as HWDATA and the B channel present them.
module tb_axi2ahb_wr_fifo;
  import axi2ahb_wr_fifo_pkg::*;

  typedef struct {
    logic [ID_BITS-1:0]   id;
    logic [DATA_BITS-1:0] data;
  } beat_t;

  typedef struct {
    logic [ID_BITS-1:0] id;
    logic [1:0]         resp;
  } bresp_t;

  logic                 clk;
  logic                 reset;
  logic [ID_BITS-1:0]   WID;
  logic [DATA_BITS-1:0] WDATA;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;
  logic [ID_BITS-1:0]   BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;
  logic [DATA_BITS-1:0] HWDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [ID_BITS-1:0]   cmd_id;
  logic                 cmd_err;
  logic                 wdata_phase;
  logic                 data_last;
  logic                 wdata_ready;

  beat_t  exp_beats[$];
  bresp_t exp_resp[$];
  int     checks = 0;
  int     errors = 0;
  logic   burst_err_m = 1'b0;
  logic   hold_v = 1'b0;
  logic [ID_BITS+1:0] hold_b;

  axi2ahb_wr_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .WID         (WID),
    .WDATA       (WDATA),
    .WLAST       (WLAST),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BID         (BID),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .cmd_id      (cmd_id),
    .cmd_err     (cmd_err),
    .wdata_phase (wdata_phase),
    .data_last   (data_last),
    .wdata_ready (wdata_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: compares each accepted B beat and holds BID/BRESP stable while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else if (BVALID && BREADY) begin
      if (exp_resp.size() == 0) begin
        check("b_unexpected", 32'(BVALID), 32'(0));
      end else begin
        bresp_t e;
        e = exp_resp.pop_front();
        check("bid", 32'(BID), 32'(e.id));
        check("bresp", 32'(BRESP), 32'(e.resp));
      end
      hold_v = 1'b0;
    end else if (BVALID) begin
      if (hold_v) check("b_stable", 32'({BID, BRESP}), 32'(hold_b));
      hold_b = {BID, BRESP};
      hold_v = 1'b1;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic axi_beat(input logic [ID_BITS-1:0] id, input logic [DATA_BITS-1:0] data,
                          input logic last);
    int n;
    n = 0;
    WID = id; WDATA = data; WLAST = last; WVALID = 1'b1;
    @(negedge clk);
    while (!WREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!WREADY) check("wready_timeout", 32'(WREADY), 32'(1));
    else exp_beats.push_back('{id, data});
    settle();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic ahb_beat(input logic [ID_BITS-1:0] id, input logic last, input logic herr,
                          input logic cerr);
    beat_t b;
    wdata_phase = 1'b1; cmd_id = id; data_last = last; cmd_err = cerr;
    HREADY = ~herr; HRESP = herr;
    @(negedge clk);
    if (exp_beats.size() == 0) begin
      check("pop_empty", 32'(1), 32'(0));
    end else begin
      b = exp_beats[0];
      check("hwdata", HWDATA, b.data);
      if (herr) begin
        settle();
        HREADY = 1'b1;
        @(negedge clk);
        check("hwdata_hold", HWDATA, b.data);
      end
      b = exp_beats.pop_front();
`ifdef AXI2AHB_WID_CHECK_EN
      if (b.id != id) burst_err_m = 1'b1;
`endif
    end
    burst_err_m = burst_err_m | herr | cerr;
    if (last) begin
      exp_resp.push_back('{id, burst_err_m ? RESP_SLVERR : RESP_OKAY});
      burst_err_m = 1'b0;
    end
    settle();
    wdata_phase = 1'b0; data_last = 1'b0; cmd_err = 1'b0; HRESP = 1'b0; HREADY = 1'b1;
  endtask

  // err_beat is 1-based; 0 means no AHB error in the burst.
  task automatic ahb_burst(input logic [ID_BITS-1:0] id, input int nbeats, input int err_beat,
                           input logic cerr);
    int n;
    n = 0;
    @(negedge clk);
    while (!wdata_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wdata_ready) check("wdata_ready_timeout", 32'(wdata_ready), 32'(1));
    settle();
    for (int i = 1; i <= nbeats; i++) ahb_beat(id, i == nbeats, i == err_beat, cerr);
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (exp_resp.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_resp.size() != 0) check("b_timeout", 32'(exp_resp.size()), 32'(0));
    settle();
  endtask

  initial begin
    reset = 1'b0; WID = '0; WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    HREADY = 1'b1; HRESP = 1'b0; cmd_id = '0; cmd_err = 1'b0; wdata_phase = 1'b0;
    data_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wready", 32'(WREADY), 32'(0));
    check("rst_bvalid", 32'(BVALID), 32'(0));
    check("rst_bid", 32'(BID), 32'(0));
    check("rst_bresp", 32'(BRESP), 32'(0));
    check("rst_hwdata", HWDATA, 32'(0));
    check("rst_wdata_ready", 32'(wdata_ready), 32'(0));
    settle();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_wready", 32'(WREADY), 32'(1));
    settle();

    // Basic 4-beat burst.
    axi_beat(3, 32'h11, 1'b0);
    axi_beat(3, 32'h22, 1'b0);
    axi_beat(3, 32'h33, 1'b0);
    @(negedge clk);
    check("t1_ready_before_last", 32'(wdata_ready), 32'(0));
    settle();
    axi_beat(3, 32'h44, 1'b1);
    @(negedge clk);
    check("t1_ready_after_last", 32'(wdata_ready), 32'(1));
    settle();
    ahb_burst(3, 4, 0, 1'b0);
    @(negedge clk);
    check("t1_ready_fall", 32'(wdata_ready), 32'(0));
    settle();
    wait_b();

    // Two-cycle AHB error on beat 2, then a clean burst.
    for (int i = 1; i <= 4; i++) axi_beat(3, 32'(i * 17), i == 4);
    ahb_burst(3, 4, 2, 1'b0);
    for (int i = 1; i <= 4; i++) axi_beat(3, 32'(32'h100 + i), i == 4);
    ahb_burst(3, 4, 0, 1'b0);
    wait_b();

    // Command-stage error.
    axi_beat(2, 32'hE0, 1'b0);
    axi_beat(2, 32'hE1, 1'b1);
    ahb_burst(2, 2, 0, 1'b1);
    wait_b();

    // Fill to CMD_DEPTH bursts, then exercise the response-full gate.
    BREADY = 1'b0;
    for (int i = 0; i < CMD_DEPTH; i++) axi_beat(ID_BITS'(i), 32'(32'hA0 + i), 1'b1);
    @(negedge clk);
    check("t3_wready_full_cnt", 32'(WREADY), 32'(0));
    check("t3_ready_full_cnt", 32'(wdata_ready), 32'(1));
    settle();
    for (int i = 0; i < CMD_DEPTH; i++) ahb_burst(ID_BITS'(i), 1, 0, 1'b0);
    axi_beat(7, 32'hB7, 1'b1);
    @(negedge clk);
    check("t3_ready_resp_full", 32'(wdata_ready), 32'(0));
    check("t3_bvalid", 32'(BVALID), 32'(1));
    settle();
    BREADY = 1'b1;
    settle();
    BREADY = 1'b0;
    @(negedge clk);
    check("t3_ready_after_pop", 32'(wdata_ready), 32'(1));
    settle();
    BREADY = 1'b1;
    ahb_burst(7, 1, 0, 1'b0);
    wait_b();

    // AXI WLAST and AHB data_last in the same cycle.
    axi_beat(8, 32'hC8, 1'b1);
    axi_beat(9, 32'hD1, 1'b0);
    fork
      axi_beat(9, 32'hD2, 1'b1);
      ahb_beat(8, 1'b1, 1'b0, 1'b0);
    join
    @(negedge clk);
    check("t4_ready_hold", 32'(wdata_ready), 32'(1));
    check("t4_wready", 32'(WREADY), 32'(1));
    settle();
    ahb_burst(9, 2, 0, 1'b0);
    wait_b();

    // Reset in the middle of a burst with a response pending.
    BREADY = 1'b0;
    axi_beat(1, 32'h55, 1'b1);
    ahb_burst(1, 1, 0, 1'b0);
    axi_beat(2, 32'h66, 1'b0);
    axi_beat(2, 32'h77, 1'b0);
    reset = 1'b0;
    #1;
    check("t5_wready", 32'(WREADY), 32'(0));
    check("t5_bvalid", 32'(BVALID), 32'(0));
    check("t5_wdata_ready", 32'(wdata_ready), 32'(0));
    check("t5_hwdata", HWDATA, 32'(0));
    exp_beats.delete();
    exp_resp.delete();
    burst_err_m = 1'b0;
    settle();
    reset = 1'b1;
    @(negedge clk);
    check("t5_wready_rel", 32'(WREADY), 32'(1));
    check("t5_ready_rel", 32'(wdata_ready), 32'(0));
    check("t5_bvalid_rel", 32'(BVALID), 32'(0));
    settle();
    BREADY = 1'b1;

    // WID differing from cmd_id: SLVERR only with the ID check built in.
    axi_beat(5, 32'h99, 1'b1);
    ahb_burst(6, 1, 0, 1'b0);
    wait_b();

    check("beats_left", 32'(exp_beats.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
